// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file with scoreboard.
package regfile_pkg;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int unsigned AW_DEF = addr_width(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port operand select: highest-index matching write port, else stored value, else zero.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     stored,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]     rd_data
);

  always_comb begin
    rd_data = stored;
    // Ascending scan so the last match (highest port index) wins.
    for (int unsigned j = 0; j < NWR; j++) begin
      if (we[j] && (wr_addr[j*AW +: AW] == rd_addr)) begin
        rd_data = wr_data[j*XLEN +: XLEN];
      end
    end
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-first bypass and per-register pending-write scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  output logic                issue_ok,
  output logic [NREGS-1:0]    pending
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] clr;
  logic             issue_zero;
  logic             issue_acc;

  always_comb begin
    regs_d = regs_q;
    clr    = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (we[j]) begin
        clr[wr_addr[j*AW +: AW]] = 1'b1;
        if (!((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0))) begin
          regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
    issue_zero = (ZERO_REG != 0) && (issue_addr == '0);
    // A writeback landing this cycle frees the register for immediate re-reservation.
    issue_acc  = issue_valid && (issue_zero || !pending_q[issue_addr] || clr[issue_addr]);
    pending_d  = pending_q & ~clr;
    if (issue_acc && !issue_zero) begin
      pending_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign issue_ok = issue_acc & ~rst;
  assign pending  = pending_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] mux_data;
    logic            ra_zero;

    assign ra      = rd_addr[i*AW +: AW];
    assign ra_zero = (ZERO_REG != 0) && (ra == '0);

    regfile_bypass_mux #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_mux (
      .rd_addr (ra),
      .stored  (regs_q[ra]),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (mux_data)
    );

    assign rd_data[i*XLEN +: XLEN] = rst ? '0 : mux_data;
    assign rd_busy[i] = pending_q[ra] & ~clr[ra] & ~ra_zero & ~rst;
  end

endmodule
